registro_solicitudes: RTL and testbench

Parametrised successor to the floor/hall button encoder. It synchronises, debounces and edge-detects every cabin and hall button, and latches each press into a pending-request bitmap that the elevator controller clears on arrival. It also presents unreported requests one at a time as an encoded code with a valid/ack handshake. It sits between the board buttons and the elevator control FSM.

---
 rtl/registro_solicitudes_pkg.sv | 46 ++++
 rtl/registro_solicitudes_if.sv | 40 ++++
 rtl/registro_solicitudes_antirrebote.sv | 60 ++++++
 rtl/registro_solicitudes.sv | 120 ++++++++++++
 tb/tb_registro_solicitudes.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/registro_solicitudes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : paquete_ascensor
//  Description : Shared types and helpers for the elevator request register:
//                default floor count, button-to-code map, code width and
//                presentation FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package paquete_ascensor;

    localparam int N_PISOS_DEF = 4;

    typedef enum logic [0:0] {
        LIBRE    = 1'b0,
        PRESENTA = 1'b1
    } estado_t;

    // Code width able to hold every code 1..3n-2 plus the "none" value 0
    function automatic int ancho_codigo(input int n);
        return $clog2(3 * n - 1);
    endfunction

    function automatic int cod_cabina(input int f);
        return f;
    endfunction

    function automatic int cod_subir(input int f, input int n);
        return n + f;
    endfunction

    function automatic int cod_bajar(input int f, input int n);
        return 2 * n - 2 + f;
    endfunction

    // Floor served by a given code; 0 when the code maps to no button
    function automatic int piso_de_codigo(input int c, input int n);
        for (int f = 1; f <= n; f++) begin
            if (cod_cabina(f) == c) return f;
            if ((f < n) && (cod_subir(f, n) == c)) return f;
            if ((f >= 2) && (cod_bajar(f, n) == c)) return f;
        end
        return 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/registro_solicitudes_if.sv
`default_nettype none
// ============================================================================
//  Module      : registro_solicitudes_if
//  Description : Button inputs, clear strobe and request presentation
//                handshake between the board, the request register and the
//                elevator controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface registro_solicitudes_if
    import paquete_ascensor::*;
#(
    parameter int N_PISOS = N_PISOS_DEF
);
    localparam int M  = 3 * N_PISOS - 2;
    localparam int CW = ancho_codigo(N_PISOS);

    logic [N_PISOS-1:0] piso;
    logic [N_PISOS-2:0] subir;
    logic [N_PISOS-2:0] bajar;
    logic               limpiar_en;
    logic [CW-1:0]      limpiar_piso;
    logic [M-1:0]       solicitudes;
    logic [CW-1:0]      boton_pres;
    logic               boton_valido;
    logic               boton_ack;

    // Board + controller side
    modport master (
        output piso, subir, bajar, limpiar_en, limpiar_piso, boton_ack,
        input  solicitudes, boton_pres, boton_valido
    );

    // Request register side
    modport slave (
        input  piso, subir, bajar, limpiar_en, limpiar_piso, boton_ack,
        output solicitudes, boton_pres, boton_valido
    );

endinterface
`default_nettype wire

// File: rtl/registro_solicitudes_antirrebote.sv
`default_nettype none
// ============================================================================
//  Module      : antirrebote
//  Description : Two-flop synchroniser, stability counter and rising-edge
//                pulse for a single button. The filtered level only follows
//                the synced input after DEB_CICLOS consecutive differing
//                cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module antirrebote #(
    parameter int DEB_CICLOS = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic boton_i,
    output logic      pulso_o
);
    localparam int                CNT_W   = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam logic [CNT_W-1:0]  CNT_FIN = CNT_W'(DEB_CICLOS - 1);

    logic [1:0]       sinc_q, sinc_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             pulso_q, pulso_d;

    // Next state: count differing cycles, accept the new level on the last one
    always_comb begin
        sinc_d  = {sinc_q[0], boton_i};
        filt_d  = filt_q;
        cnt_d   = '0;
        pulso_d = 1'b0;
        if (sinc_q[1] != filt_q) begin
            if (cnt_q == CNT_FIN) begin
                filt_d  = sinc_q[1];
                pulso_d = sinc_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; filtered level restarts at 0 so held buttons re-fire
    always_ff @(posedge clk) begin
        if (reset) begin
            sinc_q  <= '0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
            pulso_q <= 1'b0;
        end else begin
            sinc_q  <= sinc_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            pulso_q <= pulso_d;
        end
    end

    assign pulso_o = pulso_q;

endmodule
`default_nettype wire

// File: rtl/registro_solicitudes.sv
`default_nettype none
// ============================================================================
//  Module      : registro_solicitudes
//  Description : Debounces every cabin/hall button, latches presses into a
//                pending bitmap cleared by the controller on arrival, and
//                presents unreported requests one at a time (lowest code
//                first) with a valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module registro_solicitudes
    import paquete_ascensor::*;
#(
    parameter int N_PISOS    = N_PISOS_DEF,
    parameter int DEB_CICLOS = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    registro_solicitudes_if.slave  bus
);
    localparam int M  = 3 * N_PISOS - 2;
    localparam int CW = ancho_codigo(N_PISOS);

    // Concatenation order makes bit k of the vector correspond to code k+1
    logic [M-1:0]  w_botones;
    logic [M-1:0]  w_pulsos;
    logic [M-1:0]  w_limpiar;
    logic [M-1:0]  w_cand;
    logic [M-1:0]  w_sel;
    logic [M-1:0]  w_marca;
    logic [CW-1:0] w_cadena [M+1];

    logic [M-1:0]  sol_q, sol_d;
    logic [M-1:0]  rep_q, rep_d;
    logic [CW-1:0] pres_q, pres_d;
    estado_t       estado_q, estado_d;

    assign w_botones = {bus.bajar, bus.subir, bus.piso};

    generate
        for (genvar k = 0; k < M; k++) begin : g_boton
            localparam int PISO_K = piso_de_codigo(k + 1, N_PISOS);

            antirrebote #(
                .DEB_CICLOS (DEB_CICLOS)
            ) u_antirrebote (
                .clk     (clk),
                .reset   (reset),
                .boton_i (w_botones[k]),
                .pulso_o (w_pulsos[k])
            );

            // Clear hits every button of the served floor; 0 / out of range never matches
            assign w_limpiar[k] = bus.limpiar_en && (bus.limpiar_piso == CW'(PISO_K));

            // One-hot of the currently presented code
            assign w_sel[k] = (pres_q == CW'(k + 1));

            // Priority chain: lower codes override higher ones
            assign w_cadena[k] = w_cand[k] ? CW'(k + 1) : w_cadena[k+1];
        end
    endgenerate

    assign w_cadena[M] = '0;

    // A request being cleared this cycle is never offered
    assign w_cand = sol_q & ~rep_q & ~w_limpiar;

    // Bitmap, reported flags and presentation FSM next state
    always_comb begin
        sol_d    = (sol_q | w_pulsos) & ~w_limpiar;
        w_marca  = '0;
        estado_d = estado_q;
        pres_d   = pres_q;
        case (estado_q)
            LIBRE: begin
                if (|w_cand) begin
                    pres_d   = w_cadena[0];
                    estado_d = PRESENTA;
                end
            end
            PRESENTA: begin
                if ((|(w_sel & w_limpiar)) || !(|(w_sel & sol_q))) begin
                    // Withdrawal takes precedence over a simultaneous ack
                    estado_d = LIBRE;
                    pres_d   = '0;
                end else if (bus.boton_ack) begin
                    w_marca  = w_sel;
                    estado_d = LIBRE;
                    pres_d   = '0;
                end
            end
            default: begin
                estado_d = LIBRE;
                pres_d   = '0;
            end
        endcase
        rep_d = (rep_q | w_marca) & ~w_limpiar;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sol_q    <= '0;
            rep_q    <= '0;
            pres_q   <= '0;
            estado_q <= LIBRE;
        end else begin
            sol_q    <= sol_d;
            rep_q    <= rep_d;
            pres_q   <= pres_d;
            estado_q <= estado_d;
        end
    end

    assign bus.solicitudes  = sol_q;
    assign bus.boton_pres   = pres_q;
    assign bus.boton_valido = (estado_q == PRESENTA);

endmodule
`default_nettype wire

// File: tb/tb_registro_solicitudes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_registro_solicitudes
//  Description : Directed self-checking bench for registro_solicitudes with
//                four floors and a four-cycle debounce.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_registro_solicitudes;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    registro_solicitudes_if #(.N_PISOS(4)) bus ();

    registro_solicitudes #(
        .N_PISOS    (4),
        .DEB_CICLOS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] piso;
        logic [2:0] subir;
        logic [2:0] bajar;
        logic       len;
        logic [3:0] lpiso;
        logic       ack;
        logic [9:0] sol;
        logic [3:0] pres;
        logic       val;
    } vec_t;

    vec_t tabla [13];

    task automatic paso(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nombre, input logic [9:0] es,
                       input logic [3:0] ep, input logic ev);
        n_chk++;
        if (bus.solicitudes !== es || bus.boton_pres !== ep || bus.boton_valido !== ev) begin
            n_fail++;
            $display("FAIL %s: got sol=%h pres=%0d valido=%b, expected sol=%h pres=%0d valido=%b",
                     nombre, bus.solicitudes, bus.boton_pres, bus.boton_valido, es, ep, ev);
        end
    endtask

    initial begin
        // piso[2] held 10 cycles: pending after 7 edges, presented on the 8th,
        // acked, then cleared on arrival at floor 3
        for (int i = 0; i < 13; i++)
            tabla[i] = '{piso: 4'b0000, subir: 3'b000, bajar: 3'b000, len: 1'b0,
                         lpiso: 4'd0, ack: 1'b0, sol: 10'h000, pres: 4'd0, val: 1'b0};
        for (int i = 0; i < 10; i++) tabla[i].piso = 4'b0100;
        for (int i = 6; i < 12; i++) tabla[i].sol  = 10'h004;
        for (int i = 7; i < 10; i++) begin
            tabla[i].pres = 4'd3;
            tabla[i].val  = 1'b1;
        end
        tabla[10].ack   = 1'b1;
        tabla[12].len   = 1'b1;
        tabla[12].lpiso = 4'd3;

        bus.piso = '0; bus.subir = '0; bus.bajar = '0;
        bus.limpiar_en = 1'b0; bus.limpiar_piso = '0; bus.boton_ack = 1'b0;
        reset = 1'b1;
        paso(2);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("reposo[%0d]", i), 10'h000, 4'd0, 1'b0);
            paso(1);
        end

        // Table-driven single press
        for (int i = 0; i < 13; i++) begin
            bus.piso = tabla[i].piso;  bus.subir = tabla[i].subir; bus.bajar = tabla[i].bajar;
            bus.limpiar_en = tabla[i].len; bus.limpiar_piso = tabla[i].lpiso;
            bus.boton_ack = tabla[i].ack;
            paso(1);
            chk($sformatf("tabla[%0d]", i), tabla[i].sol, tabla[i].pres, tabla[i].val);
        end
        bus.limpiar_en = 1'b0; bus.limpiar_piso = '0;
        paso(8);

        // Glitches: 3 cycles rejected, 4 cycles accepted
        bus.piso = 4'b0001; paso(3); bus.piso = 4'b0000;
        paso(12);
        chk("glitch3", 10'h000, 4'd0, 1'b0);
        bus.piso = 4'b0001; paso(4); bus.piso = 4'b0000;
        paso(12);
        chk("glitch4", 10'h001, 4'd1, 1'b1);
        bus.boton_ack = 1'b1; paso(1); bus.boton_ack = 1'b0;
        chk("glitch4_ack", 10'h001, 4'd0, 1'b0);
        bus.limpiar_en = 1'b1; bus.limpiar_piso = 4'd1; paso(1); bus.limpiar_en = 1'b0;
        chk("glitch4_limpiar", 10'h000, 4'd0, 1'b0);
        paso(8);

        // S1 and B4 on the same edge, then cabin 2 arrives while 5 is shown
        bus.subir = 3'b001; bus.bajar = 3'b100;
        paso(8);
        chk("s1_b4_pres5", 10'h210, 4'd5, 1'b1);
        bus.subir = '0; bus.bajar = '0; bus.piso = 4'b0010;
        paso(8);
        chk("sin_preempcion", 10'h212, 4'd5, 1'b1);
        bus.piso = '0;
        bus.boton_ack = 1'b1; paso(1);
        chk("ack5", 10'h212, 4'd0, 1'b0);
        paso(1);                            // ack held while idle is ignored
        bus.boton_ack = 1'b0;
        chk("pres2", 10'h212, 4'd2, 1'b1);
        bus.boton_ack = 1'b1; paso(1); bus.boton_ack = 1'b0;
        chk("ack2", 10'h212, 4'd0, 1'b0);
        paso(1);
        chk("pres10", 10'h212, 4'd10, 1'b1);
        bus.boton_ack = 1'b1; paso(1); bus.boton_ack = 1'b0;
        chk("ack10", 10'h212, 4'd0, 1'b0);
        paso(1);
        chk("sin_pendientes", 10'h212, 4'd0, 1'b0);
        bus.limpiar_en = 1'b1;
        bus.limpiar_piso = 4'd1; paso(1);
        bus.limpiar_piso = 4'd2; paso(1);
        bus.limpiar_piso = 4'd4; paso(1);
        bus.limpiar_en = 1'b0;
        chk("limpieza_total", 10'h000, 4'd0, 1'b0);
        paso(8);

        // Cabin 2 and B2 pending; clearing floor 2 withdraws the shown code
        bus.piso = 4'b0010; bus.bajar = 3'b001;
        paso(8);
        chk("pres2_b2", 10'h082, 4'd2, 1'b1);
        bus.piso = '0; bus.bajar = '0;
        bus.limpiar_en = 1'b1; bus.limpiar_piso = 4'd2; paso(1); bus.limpiar_en = 1'b0;
        chk("retirada", 10'h000, 4'd0, 1'b0);
        paso(1);
        chk("retirada_sigue", 10'h000, 4'd0, 1'b0);
        paso(8);

        // S2 matures on the very edge floor 2 is cleared: clear wins
        bus.subir = 3'b010;
        paso(6);
        bus.limpiar_en = 1'b1; bus.limpiar_piso = 4'd2; paso(1); bus.limpiar_en = 1'b0;
        chk("limpiar_gana", 10'h000, 4'd0, 1'b0);
        paso(2);
        chk("limpiar_gana_sigue", 10'h000, 4'd0, 1'b0);
        bus.subir = '0;
        paso(8);

        // Out-of-range clears, reset mid-handshake, button held through reset
        bus.piso = 4'b1000;
        paso(8);
        chk("pres4", 10'h008, 4'd4, 1'b1);
        bus.limpiar_en = 1'b1; bus.limpiar_piso = 4'd0; paso(1);
        chk("limpiar_0", 10'h008, 4'd4, 1'b1);
        bus.limpiar_piso = 4'd5; paso(1); bus.limpiar_en = 1'b0;
        chk("limpiar_5", 10'h008, 4'd4, 1'b1);
        reset = 1'b1; paso(1); reset = 1'b0;
        chk("reset_medio", 10'h000, 4'd0, 1'b0);
        paso(7);
        chk("mantenido_espera", 10'h008, 4'd0, 1'b0);
        paso(1);
        chk("mantenido_reset", 10'h008, 4'd4, 1'b1);
        bus.piso = '0;
        bus.boton_ack = 1'b1; paso(1); bus.boton_ack = 1'b0;
        chk("ack4", 10'h008, 4'd0, 1'b0);
        bus.limpiar_en = 1'b1; bus.limpiar_piso = 4'd4; paso(1); bus.limpiar_en = 1'b0;
        chk("limpiar4", 10'h000, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
